key_search_controller: RTL

KEY_SEARCH_CONTROLLER -- requirements
Module: key_search_controller

---
 rtl/key_search_controller.sv | 124 ++++++++++++
 1 files changed

// File: rtl/key_search_controller.sv
// Key search sequencer: pulls candidate keys from a generator, launches the decryption core on each,
// and stops on a valid plaintext, the last key of the range, or a core watchdog expiry.
module key_search_controller #(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        go,
    output logic        gen_start,
    input  logic        gen_finished,
    input  logic        gen_terminated,
    input  logic [23:0] gen_key,
    output logic [23:0] core_key,
    output logic        core_start,
    input  logic        core_done,
    input  logic        core_valid,
    output logic        busy,
    output logic        found,
    output logic        exhausted,
    output logic        timeout,
    output logic [23:0] found_key,
    output logic [23:0] keys_tried
);

    typedef enum logic [2:0] {
        S_IDLE, S_REQ_KEY, S_WAIT_KEY, S_LAUNCH,
        S_WAIT_CORE, S_FOUND, S_EXHAUSTED, S_TIMEOUT
    } state_t;

    state_t      state;
    state_t      next_state;
    logic        go_q;
    logic        go_edge;
    logic        last;
    logic [15:0] wdog;
    logic        wdog_expire;
    logic        key_arrived;
    logic        start_search;

    assign go_edge      = go & ~go_q;
    assign key_arrived  = gen_finished | gen_terminated;
    assign wdog_expire  = (TIMEOUT_CYCLES != 16'd0) && (wdog == TIMEOUT_CYCLES - 16'd1);
    assign start_search = go_edge && (state == S_IDLE || state == S_FOUND ||
                                      state == S_EXHAUSTED || state == S_TIMEOUT);

    // go_q tracks go even during reset so a level held across reset release is not an edge.
    always_ff @(posedge clk) begin
        go_q <= go;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE, S_FOUND, S_EXHAUSTED, S_TIMEOUT: begin
                if (go_edge) next_state = S_REQ_KEY;
            end
            S_REQ_KEY:  next_state = S_WAIT_KEY;
            S_WAIT_KEY: begin
                if (key_arrived) next_state = S_LAUNCH;
            end
            S_LAUNCH:   next_state = S_WAIT_CORE;
            S_WAIT_CORE: begin
                // A completion in the expiry cycle takes priority over the watchdog.
                if (core_done) begin
                    if (core_valid)  next_state = S_FOUND;
                    else if (last)   next_state = S_EXHAUSTED;
                    else             next_state = S_REQ_KEY;
                end else if (wdog_expire) begin
                    next_state = S_TIMEOUT;
                end
            end
            default:    next_state = S_IDLE;
        endcase
    end

    always_comb begin
        gen_start  = (state == S_REQ_KEY);
        core_start = (state == S_LAUNCH);
        found      = (state == S_FOUND);
        exhausted  = (state == S_EXHAUSTED);
        timeout    = (state == S_TIMEOUT);
        busy       = !(state == S_IDLE || state == S_FOUND ||
                       state == S_EXHAUSTED || state == S_TIMEOUT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            core_key   <= 24'd0;
            found_key  <= 24'd0;
            keys_tried <= 24'd0;
            last       <= 1'b0;
            wdog       <= 16'd0;
        end else begin
            if (start_search) begin
                keys_tried <= 24'd0;
                found_key  <= 24'd0;
            end
            if (state == S_WAIT_KEY && key_arrived) begin
                core_key <= gen_key;
                last     <= gen_terminated;
            end
            if (state == S_LAUNCH) begin
                wdog <= 16'd0;
            end
            if (state == S_WAIT_CORE) begin
                if (core_done) begin
                    if (keys_tried != 24'hFFFFFF) keys_tried <= keys_tried + 24'd1;
                    if (core_valid) found_key <= core_key;
                end else begin
                    wdog <= wdog + 16'd1;
                end
            end
        end
    end

endmodule
